// File: rtl/fetch_sequencer.sv
// Multicycle fetch/decode controller for the rvsimple core: owns pc and the instruction register.
// Optional feature: define RVSIMPLE_FETCH_ILLEGAL_CHECK_EN to add the registered inst_illegal output.

module instruction_decoder (
  input  logic [31:0] inst,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

endmodule

module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          WAIT_LIMIT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  inst_opcode,
  output logic [2:0]  inst_funct3,
  output logic [6:0]  inst_funct7,
  output logic [4:0]  inst_rd,
  output logic [4:0]  inst_rs1,
  output logic [4:0]  inst_rs2,
  output logic        fetch_fault
`ifdef RVSIMPLE_FETCH_ILLEGAL_CHECK_EN
  ,
  output logic        inst_illegal
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID,
    FAULT
  } state_t;

  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   fetch_addr;
  logic [CW-1:0] wait_cnt;
  logic          discard;
  logic [31:0]   redirect_target;
  logic          timeout_hit;

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign timeout_hit     = (WAIT_LIMIT != 0) && (wait_cnt == CW'(WAIT_LIMIT - 1));

  // fetch_addr is separate from pc so an outstanding request keeps its address after a redirect
  assign imem_addr = fetch_addr;

`ifdef RVSIMPLE_FETCH_ILLEGAL_CHECK_EN
  logic rdata_illegal;
  assign rdata_illegal = (imem_rdata[1:0] != 2'b11) || (imem_rdata == 32'h0000_0000) ||
                         (imem_rdata == 32'hFFFF_FFFF);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      fetch_addr  <= RESET_PC;
      imem_req    <= 1'b0;
      inst_valid  <= 1'b0;
      inst        <= NOP;
      inst_pc     <= RESET_PC;
      fetch_fault <= 1'b0;
      wait_cnt    <= '0;
      discard     <= 1'b0;
`ifdef RVSIMPLE_FETCH_ILLEGAL_CHECK_EN
      inst_illegal <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
          if (redirect_valid) begin
            pc         <= redirect_target;
            fetch_addr <= redirect_target;
          end else begin
            fetch_addr <= pc;
          end
        end

        FETCH: begin
          if (imem_ack) begin
            wait_cnt <= '0;
            if (redirect_valid) begin
              pc         <= redirect_target;
              fetch_addr <= redirect_target;
              discard    <= 1'b0;
            end else if (discard) begin
              discard    <= 1'b0;
              fetch_addr <= pc;
            end else begin
              inst       <= imem_rdata;
              inst_pc    <= fetch_addr;
              pc         <= fetch_addr + 32'd4;
              state      <= VALID;
              imem_req   <= 1'b0;
              inst_valid <= 1'b1;
`ifdef RVSIMPLE_FETCH_ILLEGAL_CHECK_EN
              inst_illegal <= rdata_illegal;
`endif
            end
          end else if (timeout_hit) begin
            state       <= FAULT;
            imem_req    <= 1'b0;
            fetch_fault <= 1'b1;
          end else begin
            if (WAIT_LIMIT != 0) wait_cnt <= wait_cnt + CW'(1);
            // The bus request is still in flight, so only remember to drop its data
            if (redirect_valid) begin
              pc      <= redirect_target;
              discard <= 1'b1;
            end
          end
        end

        VALID: begin
          if (redirect_valid) begin
            pc         <= redirect_target;
            fetch_addr <= redirect_target;
            state      <= FETCH;
            inst_valid <= 1'b0;
            imem_req   <= 1'b1;
          end else if (inst_ready) begin
            fetch_addr <= pc;
            state      <= FETCH;
            inst_valid <= 1'b0;
            imem_req   <= 1'b1;
          end
        end

        FAULT: begin
          imem_req    <= 1'b0;
          inst_valid  <= 1'b0;
          fetch_fault <= 1'b1;
        end

        default: begin
          state <= FAULT;
        end
      endcase
    end
  end

  instruction_decoder u_decoder (
    .inst   (inst),
    .opcode (inst_opcode),
    .funct3 (inst_funct3),
    .funct7 (inst_funct7),
    .rd     (inst_rd),
    .rs1    (inst_rs1),
    .rs2    (inst_rs2)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: vector table for fetch/decode plus hand-built redirect,
// stall and timeout sequences (timeout uses a second instance with WAIT_LIMIT=4).

module tb_fetch_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  inst_opcode;
  logic [2:0]  inst_funct3;
  logic [6:0]  inst_funct7;
  logic [4:0]  inst_rd;
  logic [4:0]  inst_rs1;
  logic [4:0]  inst_rs2;
  logic        fetch_fault;

  logic        reset4_n;
  logic        imem_req4;
  logic [31:0] imem_addr4;
  logic        imem_ack4;
  logic [31:0] imem_rdata4;
  logic        redirect_valid4;
  logic [31:0] redirect_pc4;
  logic        inst_valid4;
  logic        inst_ready4;
  logic [31:0] inst4;
  logic [31:0] inst_pc4;
  logic [6:0]  inst_opcode4;
  logic [2:0]  inst_funct34;
  logic [6:0]  inst_funct74;
  logic [4:0]  inst_rd4;
  logic [4:0]  inst_rs14;
  logic [4:0]  inst_rs24;
  logic        fetch_fault4;

`ifdef RVSIMPLE_FETCH_ILLEGAL_CHECK_EN
  logic inst_illegal;
  logic inst_illegal4;
`endif

  fetch_sequencer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_opcode    (inst_opcode),
    .inst_funct3    (inst_funct3),
    .inst_funct7    (inst_funct7),
    .inst_rd        (inst_rd),
    .inst_rs1       (inst_rs1),
    .inst_rs2       (inst_rs2),
    .fetch_fault    (fetch_fault)
`ifdef RVSIMPLE_FETCH_ILLEGAL_CHECK_EN
    ,
    .inst_illegal   (inst_illegal)
`endif
  );

  fetch_sequencer #(.WAIT_LIMIT(4)) dut4 (
    .clock          (clock),
    .reset_n        (reset4_n),
    .imem_req       (imem_req4),
    .imem_addr      (imem_addr4),
    .imem_ack       (imem_ack4),
    .imem_rdata     (imem_rdata4),
    .redirect_valid (redirect_valid4),
    .redirect_pc    (redirect_pc4),
    .inst_valid     (inst_valid4),
    .inst_ready     (inst_ready4),
    .inst           (inst4),
    .inst_pc        (inst_pc4),
    .inst_opcode    (inst_opcode4),
    .inst_funct3    (inst_funct34),
    .inst_funct7    (inst_funct74),
    .inst_rd        (inst_rd4),
    .inst_rs1       (inst_rs14),
    .inst_rs2       (inst_rs24),
    .fetch_fault    (fetch_fault4)
`ifdef RVSIMPLE_FETCH_ILLEGAL_CHECK_EN
    ,
    .inst_illegal   (inst_illegal4)
`endif
  );

  typedef struct {
    logic [31:0] rdata;
    int          delay;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic        illegal;
  } vec_t;

  vec_t vecs[8];
  int   totalCount = 0;
  int   passCount  = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic ack, input logic [31:0] rdata, input logic ready,
                               input logic redir, input logic [31:0] rpc);
    imem_ack       = ack;
    imem_rdata     = rdata;
    inst_ready     = ready;
    redirect_valid = redir;
    redirect_pc    = rpc;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] expAddr;

    vecs[0] = '{32'h0050_0093,  5, 7'h13, 5'd1,  3'd0, 5'd0,  5'd5,  7'h00, 1'b0};
    vecs[1] = '{32'h0020_81B3,  0, 7'h33, 5'd3,  3'd0, 5'd1,  5'd2,  7'h00, 1'b0};
    vecs[2] = '{32'h4020_8033, 15, 7'h33, 5'd0,  3'd0, 5'd1,  5'd2,  7'h20, 1'b0};
    vecs[3] = '{32'h0000_A103,  1, 7'h03, 5'd2,  3'd2, 5'd1,  5'd0,  7'h00, 1'b0};
    vecs[4] = '{32'h0000_0000,  2, 7'h00, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 1'b1};
    vecs[5] = '{32'hFFFF_FFFF,  0, 7'h7F, 5'd31, 3'd7, 5'd31, 5'd31, 7'h7F, 1'b1};
    vecs[6] = '{32'h1234_5678,  3, 7'h78, 5'd12, 3'd5, 5'd8,  5'd3,  7'h09, 1'b1};
    vecs[7] = '{32'h0000_0013,  0, 7'h13, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 1'b0};

    reset_n         = 1'b0;
    reset4_n        = 1'b0;
    imem_ack4       = 1'b0;
    imem_rdata4     = 32'h0;
    redirect_valid4 = 1'b0;
    redirect_pc4    = 32'h0;
    inst_ready4     = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();

    checkOutput("reset imem_req", imem_req, 0);
    checkOutput("reset inst_valid", inst_valid, 0);
    checkOutput("reset inst", inst, 32'h0000_0013);
    checkOutput("reset inst_pc", inst_pc, 32'h0);
    checkOutput("reset fetch_fault", fetch_fault, 0);
    checkOutput("reset opcode", inst_opcode, 7'h13);
    checkOutput("reset rd", inst_rd, 0);
`ifdef RVSIMPLE_FETCH_ILLEGAL_CHECK_EN
    checkOutput("reset inst_illegal", inst_illegal, 0);
`endif

    // Back-to-back with ack and ready held high
    reset_n = 1'b1;
    applyStimulus(1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("first req", imem_req, 1);
    checkOutput("first addr", imem_addr, 32'h0);
    tick();
    checkOutput("first valid", inst_valid, 1);
    checkOutput("first inst_pc", inst_pc, 32'h0);
    checkOutput("req low in valid", imem_req, 0);
    tick();
    checkOutput("second req", imem_req, 1);
    checkOutput("second addr", imem_addr, 32'h4);
    checkOutput("valid low in fetch", inst_valid, 0);
    tick();
    checkOutput("second inst_pc", inst_pc, 32'h4);
    tick();
    checkOutput("third addr", imem_addr, 32'h8);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 8; i++) begin
      expAddr = 32'h8 + 32'(4 * i);
      for (int d = 0; d < vecs[i].delay; d++) begin
        checkOutput("wait req", imem_req, 1);
        checkOutput("wait addr stable", imem_addr, expAddr);
        tick();
      end
      checkOutput("pre-ack addr", imem_addr, expAddr);
      checkOutput("pre-ack valid", inst_valid, 0);
      applyStimulus(1'b1, vecs[i].rdata, 1'b0, 1'b0, 32'h0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("vec valid", inst_valid, 1);
      checkOutput("vec inst", inst, vecs[i].rdata);
      checkOutput("vec inst_pc", inst_pc, expAddr);
      checkOutput("vec opcode", inst_opcode, vecs[i].opcode);
      checkOutput("vec rd", inst_rd, vecs[i].rd);
      checkOutput("vec funct3", inst_funct3, vecs[i].funct3);
      checkOutput("vec rs1", inst_rs1, vecs[i].rs1);
      checkOutput("vec rs2", inst_rs2, vecs[i].rs2);
      checkOutput("vec funct7", inst_funct7, vecs[i].funct7);
      checkOutput("vec fault", fetch_fault, 0);
`ifdef RVSIMPLE_FETCH_ILLEGAL_CHECK_EN
      checkOutput("vec inst_illegal", inst_illegal, vecs[i].illegal);
`endif
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("accept valid", inst_valid, 0);
      checkOutput("accept req", imem_req, 1);
      checkOutput("accept next addr", imem_addr, expAddr + 32'd4);
    end

    // Execute stalls for 10 cycles
    applyStimulus(1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 10; k++) begin
      tick();
      checkOutput("stall valid", inst_valid, 1);
      checkOutput("stall req", imem_req, 0);
      checkOutput("stall inst", inst, 32'h0050_0093);
      checkOutput("stall inst_pc", inst_pc, 32'h28);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("post-stall addr", imem_addr, 32'h2C);

    // Redirect while the request to 0x2C is outstanding
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h103);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("redir outstanding addr", imem_addr, 32'h2C);
    checkOutput("redir outstanding req", imem_req, 1);
    tick();
    checkOutput("redir addr still held", imem_addr, 32'h2C);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("discarded valid", inst_valid, 0);
    checkOutput("discarded req", imem_req, 1);
    checkOutput("redir new addr", imem_addr, 32'h100);
    applyStimulus(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("redir valid", inst_valid, 1);
    checkOutput("redir inst_pc", inst_pc, 32'h100);
    checkOutput("redir inst", inst, 32'h0000_0013);

    // Redirect in VALID together with inst_ready
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("valid-redir valid", inst_valid, 0);
    checkOutput("valid-redir req", imem_req, 1);
    checkOutput("valid-redir addr", imem_addr, 32'h200);

    // Redirect coincident with ack, target near the top of memory
    applyStimulus(1'b1, 32'hAAAA_AAAB, 1'b0, 1'b1, 32'hFFFF_FFFE);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("ack-redir valid", inst_valid, 0);
    checkOutput("ack-redir req", imem_req, 1);
    checkOutput("ack-redir addr", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("top inst_pc", inst_pc, 32'hFFFF_FFFC);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap addr", imem_addr, 32'h0);
    checkOutput("wrap req", imem_req, 1);
    applyStimulus(1'b1, 32'h0000_0093, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap inst_pc", inst_pc, 32'h0);
    checkOutput("wrap valid", inst_valid, 1);

    // Asynchronous reset assertion mid-cycle
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset valid", inst_valid, 0);
    checkOutput("async reset inst", inst, 32'h0000_0013);
    checkOutput("async reset req", imem_req, 0);

    // Timeout on the WAIT_LIMIT=4 instance
    reset4_n = 1'b1;
    tick();
    checkOutput("t/o first req", imem_req4, 1);
    checkOutput("t/o first addr", imem_addr4, 32'h0);
    tick();
    tick();
    tick();
    checkOutput("t/o 4th cycle fault", fetch_fault4, 0);
    checkOutput("t/o 4th cycle req", imem_req4, 1);
    tick();
    checkOutput("t/o fault", fetch_fault4, 1);
    checkOutput("t/o req", imem_req4, 0);
    checkOutput("t/o valid", inst_valid4, 0);
    redirect_valid4 = 1'b1;
    redirect_pc4    = 32'h40;
    tick();
    redirect_valid4 = 1'b0;
    checkOutput("fault ignores redirect", fetch_fault4, 1);
    checkOutput("fault req stays low", imem_req4, 0);
    #2;
    reset4_n = 1'b0;
    #1;
    checkOutput("fault cleared by reset", fetch_fault4, 0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
